// File: rtl/pe_input_pkg.sv
// Shared ring-router definitions: packet geometry, per-VC FSM encoding and
// the request/grant bundles exchanged with the PE-injection VC buffers.
package pe_input_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int DIR_BIT    = 62;
  localparam int VC_BIT     = 63;
  localparam int NUM_VC     = 2;
  localparam int VC_EVEN    = 0;
  localparam int VC_ODD     = 1;

  typedef logic [DATA_WIDTH-1:0] pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_REQ   = 3'b010,
    ST_DRAIN = 3'b100
  } vc_state_e;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  typedef struct packed {
    logic grant_cw;
    logic grant_ccw;
  } vc_gnt_t;

  typedef struct packed {
    logic req_cw;
    logic req_ccw;
    pkt_t data;
  } vc_rsp_t;
endpackage

// File: rtl/pe_input_if.sv
// PE handshake plus the per-VC arbiter request/grant/data bundle of one node.
interface pe_input_if;
  import pe_input_pkg::*;

  logic pesi;
  logic peri;
  pkt_t pedi;
  logic request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd;
  logic grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd;
  pkt_t data_out_even_cw, data_out_even_ccw;
  pkt_t data_out_odd_cw, data_out_odd_ccw;

  modport master (
    output pesi, pedi,
    output grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd,
    input  peri,
    input  request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd,
    input  data_out_even_cw, data_out_even_ccw, data_out_odd_cw, data_out_odd_ccw
  );

  modport slave (
    input  pesi, pedi,
    input  grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd,
    output peri,
    output request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd,
    output data_out_even_cw, data_out_even_ccw, data_out_odd_cw, data_out_odd_ccw
  );
endinterface

// File: rtl/pe_input_vc.sv
// One virtual channel's injection buffer: holds a packet, requests the ring
// named by its header and waits for the grant to rise and then fall.
module pe_input_vc
  import pe_input_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    accept_en_i,
  input  pkt_t    data_i,
  input  vc_gnt_t gnt_i,
  output logic    busy_o,
  output vc_rsp_t rsp_o
);
  vc_state_e state_q, state_d;
  pkt_t      buf_q;
  dir_e      dir;
  logic      gnt_sel;
  logic      accept;

  assign dir     = dir_e'(buf_q[DIR_BIT]);
  assign gnt_sel = (dir == DIR_CCW) ? gnt_i.grant_ccw : gnt_i.grant_cw;
  assign accept  = accept_en_i & (state_q == ST_IDLE);

  // Buffer only loads on accept so data_out stays valid while the grant is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) buf_q <= data_i;
    end
  end

  // DRAIN waits for grant low so a lingering grant cannot consume a refill.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)   state_d = ST_REQ;
      ST_REQ:   if (gnt_sel)  state_d = ST_DRAIN;
      ST_DRAIN: if (!gnt_sel) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign rsp_o.req_cw  = (state_q == ST_REQ) && (dir == DIR_CW);
  assign rsp_o.req_ccw = (state_q == ST_REQ) && (dir == DIR_CCW);
  assign rsp_o.data    = buf_q;
endmodule

// File: rtl/pe_input.sv
// PE-injection side of a ring router node: steers the PE packet into the
// VC selected by the global polarity and fans the VC buffers out to both rings.
module pe_input
  import pe_input_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        polarity,
  pe_input_if.slave   bus
);
  logic [NUM_VC-1:0]          busy;
  logic [NUM_VC-1:0]          accept_en;
  vc_gnt_t [NUM_VC-1:0]       gnt;
  vc_rsp_t [NUM_VC-1:0]       rsp;
  logic                       peri;

  assign peri     = ~rst & ~busy[polarity];
  assign bus.peri = peri;

  assign gnt[VC_EVEN] = '{grant_cw: bus.grant_cw_even, grant_ccw: bus.grant_ccw_even};
  assign gnt[VC_ODD]  = '{grant_cw: bus.grant_cw_odd,  grant_ccw: bus.grant_ccw_odd};

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign accept_en[v] = bus.pesi & peri & (polarity == 1'(v));

    pe_input_vc u_vc (
      .clk         (clk),
      .rst         (rst),
      .accept_en_i (accept_en[v]),
      .data_i      (bus.pedi),
      .gnt_i       (gnt[v]),
      .busy_o      (busy[v]),
      .rsp_o       (rsp[v])
    );
  end

  assign bus.request_cw_even   = rsp[VC_EVEN].req_cw;
  assign bus.request_ccw_even  = rsp[VC_EVEN].req_ccw;
  assign bus.request_cw_odd    = rsp[VC_ODD].req_cw;
  assign bus.request_ccw_odd   = rsp[VC_ODD].req_ccw;
  assign bus.data_out_even_cw  = rsp[VC_EVEN].data;
  assign bus.data_out_even_ccw = rsp[VC_EVEN].data;
  assign bus.data_out_odd_cw   = rsp[VC_ODD].data;
  assign bus.data_out_odd_ccw  = rsp[VC_ODD].data;
endmodule

// File: tb/tb_pe_input.sv
// Directed plus random bench for pe_input against a cycle-level packet model.
module tb_pe_input;
  logic clk = 1'b0;
  logic rst;
  logic polarity;
  pe_input_if bus ();

  pe_input dut (.clk(clk), .rst(rst), .polarity(polarity), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: per VC, whether a packet is held, whether it was already granted
  // (waiting for the grant to go away), and the held packet.
  bit          occ    [2];
  bit          handed [2];
  logic [63:0] pkt    [2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic grant_of(int v, bit ccw);
    if (v == 0) return ccw ? bus.grant_ccw_even : bus.grant_cw_even;
    return ccw ? bus.grant_ccw_odd : bus.grant_cw_odd;
  endfunction

  function automatic logic exp_req(int v, bit ccw);
    return occ[v] && !handed[v] && (pkt[v][62] == ccw);
  endfunction

  task automatic check_outputs();
    chk("peri", bus.peri, 64'(!rst && !occ[polarity]));
    chk("req_cw_even",  bus.request_cw_even,  64'(exp_req(0, 1'b0)));
    chk("req_ccw_even", bus.request_ccw_even, 64'(exp_req(0, 1'b1)));
    chk("req_cw_odd",   bus.request_cw_odd,   64'(exp_req(1, 1'b0)));
    chk("req_ccw_odd",  bus.request_ccw_odd,  64'(exp_req(1, 1'b1)));
    chk("data_even_cw",  bus.data_out_even_cw,  pkt[0]);
    chk("data_even_ccw", bus.data_out_even_ccw, pkt[0]);
    chk("data_odd_cw",   bus.data_out_odd_cw,   pkt[1]);
    chk("data_odd_ccw",  bus.data_out_odd_ccw,  pkt[1]);
  endtask

  task automatic update_model();
    for (int v = 0; v < 2; v++) begin
      if (rst) begin
        occ[v] = 1'b0; handed[v] = 1'b0; pkt[v] = '0;
      end else if (!occ[v]) begin
        if (bus.pesi && (int'(polarity) == v)) begin
          occ[v] = 1'b1; pkt[v] = bus.pedi;
        end
      end else if (!handed[v]) begin
        if (grant_of(v, pkt[v][62])) handed[v] = 1'b1;
      end else if (!grant_of(v, pkt[v][62])) begin
        occ[v] = 1'b0; handed[v] = 1'b0;
      end
    end
  endtask

  // Inputs are changed at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
    polarity = ~polarity;
  endtask

  task automatic wait_phase(bit p);
    while (polarity !== p) cycle();
  endtask

  task automatic set_grants(bit ce, bit cce, bit co, bit cco);
    bus.grant_cw_even = ce; bus.grant_ccw_even = cce;
    bus.grant_cw_odd  = co; bus.grant_ccw_odd  = cco;
  endtask

  initial begin
    logic [63:0] r;
    rst = 1'b1; polarity = 1'b0;
    bus.pesi = 1'b0; bus.pedi = '0;
    set_grants(0, 0, 0, 0);
    for (int v = 0; v < 2; v++) begin occ[v] = 0; handed[v] = 0; pkt[v] = '0; end
    @(negedge clk);

    // Reset for two cycles with polarity toggling.
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("peri_after_reset", bus.peri, 64'(1));
    cycle();

    // Single cw packet on even VC, granted for 3 cycles.
    wait_phase(1'b0);
    bus.pesi = 1'b1; bus.pedi = 64'h0000_0000_0000_00A5;
    cycle();
    bus.pesi = 1'b0;
    #1;
    chk("single_req_cw_even", bus.request_cw_even, 64'(1));
    chk("single_data_even", bus.data_out_even_cw, 64'h0000_0000_0000_00A5);
    set_grants(1, 0, 0, 0);
    repeat (3) cycle();
    set_grants(0, 0, 0, 0);
    repeat (2) cycle();

    // ccw packet on odd VC.
    wait_phase(1'b1);
    bus.pesi = 1'b1; bus.pedi = 64'h4000_0000_0000_0001;
    cycle();
    bus.pesi = 1'b0;
    #1;
    chk("ccw_req_ccw_odd", bus.request_ccw_odd, 64'(1));
    chk("ccw_req_cw_odd", bus.request_cw_odd, 64'(0));
    cycle();
    set_grants(0, 0, 0, 1);
    cycle();
    set_grants(0, 0, 0, 0);
    repeat (2) cycle();

    // Back-pressure: even VC held in REQ while pesi stays high.
    wait_phase(1'b0);
    for (int i = 0; i < 11; i++) begin
      r = {$urandom, $urandom};
      r[62] = 1'b0;
      bus.pesi = 1'b1; bus.pedi = r;
      cycle();
    end
    bus.pesi = 1'b0;

    // Stale grant: both VCs handed off, grants kept high, new packets offered.
    set_grants(1, 0, 1, 0);
    repeat (2) cycle();
    for (int i = 0; i < 4; i++) begin
      bus.pesi = 1'b1; bus.pedi = {$urandom, $urandom} & 64'hBFFF_FFFF_FFFF_FFFF;
      cycle();
    end
    set_grants(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.pedi = {$urandom, $urandom} & 64'hBFFF_FFFF_FFFF_FFFF;
      cycle();
    end
    bus.pesi = 1'b0;
    repeat (3) cycle();

    // Odd VC into DRAIN while even stays in REQ, then reset mid-operation.
    set_grants(0, 0, 1, 0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("mid_reset_req_cw_even", bus.request_cw_even, 64'(0));
    chk("mid_reset_data_even", bus.data_out_even_cw, 64'(0));
    set_grants(0, 0, 0, 0);
    repeat (2) cycle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bus.pesi = 1'($urandom_range(0, 1));
      bus.pedi = {$urandom, $urandom};
      set_grants(($urandom % 3) == 0, ($urandom % 3) == 0,
                 ($urandom % 3) == 0, ($urandom % 3) == 0);
      rst = (($urandom % 64) == 0);
      cycle();
    end
    rst = 1'b0; bus.pesi = 1'b0;
    set_grants(0, 0, 0, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_input.md
# pe_input

PE-injection side of the ring router node. Accepts one 64-bit packet at a time from the local PE over the pesi/peri/pedi handshake and holds it in a one-entry buffer per virtual channel (even, odd). It then requests the cw or ccw output channel named in the packet header and holds the packet until that output's arbiter grants it. It is the counterpart to the PE output block, which delivers ring traffic to the PE.

## Interface
- DATA_WIDTH, 64, packet width.
- DIR_BIT, 62, header bit selecting the output ring: 0 = cw, 1 = ccw.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- polarity  input  1  global phase. 0 = even VC on the external/PE link; 1 = odd VC.
- pesi  input  1  PE send valid.
- peri  output  1  router ready for PE.
- pedi  input  DATA_WIDTH  PE packet.
- request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd  output  1 each  request to the cw/ccw output arbiter, per VC.
- grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd  input  1 each  grant from the arbiter.
- data_out_even_cw, data_out_even_ccw  output  DATA_WIDTH  even buffer contents, driven to both outputs.
- data_out_odd_cw, data_out_odd_ccw  output  DATA_WIDTH  odd buffer contents, driven to both outputs.

## Operation
- **Phase VC:** the VC being filled this cycle is even when polarity=0 and odd when polarity=1.
- **Per-VC FSM**, one-hot, 3 states:
  - IDLE: buffer empty.
  - REQ: buffer full, request high on the direction from DIR_BIT.
  - DRAIN: packet handed off; waiting for the grant to fall.
- **peri:** combinational. peri = ~rst & (phase VC state == IDLE).
- **Accept:** on a rising edge with pesi & peri, pedi is written to the phase-VC buffer and that VC goes IDLE→REQ. pesi while peri=0 is ignored; no packet is stored and no error is raised.
- **Request:**
  - In REQ, request_<dir>_<vc> = 1 and the other direction's request for that VC = 0. Requests are combinational from state plus the stored DIR_BIT.
  - All requests are 0 in IDLE and DRAIN.
- **Grant:** in REQ, a sampled grant_<dir>_<vc>=1 moves REQ→DRAIN. A grant on the non-requested direction is ignored.
- **Drain:** in DRAIN, a sampled grant_<dir>_<vc>=0 moves DRAIN→IDLE.
  - This blocks a refilled buffer from being consumed by a stale, still-high grant.
  - DRAIN may last many cycles, because the output side holds its grant until the PE accepts.
- **Buffer hold:** buffer registers change only on accept. data_out is not cleared on handoff, so it stays stable through the cycle in which the grant is sampled.
- **No header modification:** hop and VC fields pass through unchanged.
- **VC independence:** the even and odd FSMs run independently. Both VCs may request at the same time, on the same or different directions.
- **Reset:** rst=1 forces both FSMs to IDLE and clears both buffers to 0. It takes priority over every event, including mid-REQ and mid-DRAIN; the held packet is lost.

## Timing
- Reset values: all requests 0, all data_out 0. peri is 0 while rst=1 and 1 on the first cycle after.
- Accept at edge N → request high in cycle N+1.
- Grant sampled high at edge M → request low in cycle M+1.
- With the grant low at edge M+1, the VC re-accepts at edge M+2 at the earliest, if its phase is current.
- A VC can accept only in the cycles where its phase is current. Because polarity toggles every cycle, the minimum spacing between back-to-back packets into one VC is 4 cycles.
- Simultaneous grant-fall and pesi on the same VC: DRAIN→IDLE happens at that edge. peri was 0 during that cycle, so no accept occurs.

## Structure
- Shared router package holds: DATA_WIDTH, DIR_BIT, VC bit position, the 3-state one-hot encoding (IDLE=3'b001, REQ=3'b010, DRAIN=3'b100), and the direction encoding.
- Sub-module pe_input_vc holds one VC's FSM, buffer and request/grant logic, with an accept-enable input and a busy output. Instantiate it twice. The top level holds only the polarity steering, the peri mux and the port fan-out.

## Test plan
- **Reset and ready:** rst for 2 cycles, then release with polarity toggling → all outputs 0 during reset. peri=1 on the first cycle after release; both FSMs IDLE.
- **Single cw packet:** pesi=1 with pedi=64'h0000_0000_0000_00A5 (bit62=0) at polarity=0 → request_cw_even=1 next cycle; data_out_even_cw=..A5. Assert grant_cw_even for 3 cycles → request drops 1 cycle after the first grant. peri for the even phase returns only after the grant falls.
- **ccw on odd VC:** pedi=64'h4000_0000_0000_0001 at polarity=1 → request_ccw_odd=1; request_cw_odd and both even requests stay 0.
- **Back-pressure:** with the even VC in REQ and no grant, hold pesi=1 for 10 cycles → peri=0 on every polarity=0 cycle. The buffer is unchanged. The odd VC still accepts on its polarity=1 cycles.
- **Stale grant:** after a handoff, keep grant_cw_even high and attempt a new even packet → rejected (peri=0) until the grant falls. The new packet is then accepted and requested exactly once.
- **Reset mid-operation:** assert rst while the even VC is in REQ and the odd VC is in DRAIN → next cycle all requests are 0, data_out is 0 and both VCs are IDLE.
